z3_master_cycle: RTL and testbench
==================================

# z3_master_cycle

Zorro III bus-master cycle sequencer for the A4092. Once the master arbiter grants the bus (BMASTER high), it turns each NCR 53C710 DMA request into one Zorro III cycle. It drives FCS_n, READ, DOE and the four data strobes, and waits for the slave's DTACK_n or BERR_n. It then returns a one-cycle acknowledge or error to the NCR side.

## Interface
Parameters:
- ADDR_SETUP, 1: CLK cycles FCS_n is held low before DOE/DS assert; legal 1..7.
- TIMEOUT_CYCLES, 255: CLK cycles in DATA before a timeout error; legal 2..1023.

Ports:
- CLK  in  1  25 MHz card clock; all logic on posedge.
- IORST_n  in  1  reset, asynchronous, active-low.
- BMASTER  in  1  bus granted to card (arbiter output, CLK-synchronous).
- mreq  in  1  NCR requests a cycle; held until mack or mberr.
- mread  in  1  1 = read, 0 = write; sampled with mreq.
- msiz  in  2  transfer size: 00 long, 01 byte, 10 word, 11 three-byte.
- maddr  in  2  A[1:0] of the transfer.
- DTACK_n  in  1  Zorro slave acknowledge (asynchronous).
- BERR_n  in  1  Zorro bus error (asynchronous).
- FCS_n  out  1  Zorro full cycle strobe.
- READ  out  1  Zorro direction.
- DOE  out  1  data output enable.
- DS_n  out  4  byte strobes; DS_n[3] = D31:24 (offset 0).
- d_le  out  1  one-cycle read-data latch enable.
- mack  out  1  one-cycle transfer acknowledge to NCR.
- mberr  out  1  one-cycle error to NCR.
- timeout  out  1  sticky; set when a timeout occurs, cleared on the next accepted mreq.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- DTACK_n and BERR_n each pass through a 2-flop synchroniser that resets to 1; the state machine uses only the synchronised copies (dt_s, be_s).
- States:
  - IDLE:
    - On mreq & BMASTER: latch mread, msiz, maddr; clear timeout; go to ADDR.
    - Otherwise stay.
  - ADDR: FCS_n=0, READ=latched mread. Stay ADDR_SETUP cycles, then go to DATA.
  - DATA: FCS_n=0, DOE=1, DS_n=lane mask, timer counting.
    - If be_s==0: go to ERR.
    - Else if dt_s==0: go to ACK.
    - Else if timer reaches TIMEOUT_CYCLES: set timeout, go to ERR.
  - ACK: mack=1, d_le=latched read, strobes still driven; next state RECOV.
  - ERR: mberr=1, strobes still driven; next state RECOV.
  - RECOV: FCS_n=1, DS_n=F, DOE=0. Wait for dt_s==1 && be_s==1, then go to IDLE.
- Lane mask:
  - n = 4 if msiz==00, else msiz.
  - Offsets maddr .. min(maddr+n-1, 3) are active; offset k drives DS_n[3-k] low.
  - Examples: long@0 → 0000; word@2 → 1100; byte@3 → 1110; 3-byte@1 → 1000; long@2 → 1100 (truncated at lane boundary).
- BMASTER falls in ADDR or DATA: go to ERR next cycle (mberr pulse, no mack).
- be_s and dt_s both low in the same DATA cycle: BERR wins.
- mreq dropping before termination is ignored; the cycle completes.
- The timer is at least $clog2(TIMEOUT_CYCLES+1) bits, clears on entry to DATA, and saturates.

## Timing
- Reset values: FCS_n=1, DS_n=4'hF, DOE=0, READ=1, d_le=0, mack=0, mberr=0, timeout=0, busy=0, state IDLE, synchronisers 1.
- Outputs are registered and change only on posedge CLK.
- Request edge to FCS_n low: 1 cycle.
- FCS_n low to DOE/DS: ADDR_SETUP cycles.
- DTACK_n pin falling to mack: 2 sync cycles + 1 (ACK) = 3 cycles minimum.
- Minimum cycle with ADDR_SETUP=1: IDLE→ADDR→DATA→…→ACK→RECOV→IDLE. Back-to-back requests get at least one RECOV cycle with FCS_n high.
- IORST_n asserted mid-cycle: all outputs go to reset values immediately (asynchronous); no mack or mberr is issued.

## Configuration
- Z3M_TIMEOUT_EN defined: the DATA-state timer and the timeout output are active as above.
- Undefined: no timer is built; DATA waits indefinitely for DTACK/BERR/BMASTER loss; timeout is tied to 0.

## Structure
- Package z3_pkg (shared with other Zorro III blocks):
  - state enum (IDLE, ADDR, DATA, ACK, ERR, RECOV);
  - SIZ encodings;
  - DS lane-index constants.
- Sub-module z3_lane_decode (combinational): msiz, maddr → 4-bit DS_n mask. Reusable by the slave-side strobe logic.

## Test plan
- Long read @0, DTACK_n low 4 cycles after DS: DS_n=0000, READ=1; d_le and mack pulse together 3 cycles after DTACK_n; FCS_n high the next cycle.
- Byte write @3, ADDR_SETUP=2: FCS_n low 2 cycles before DOE=1 and DS_n=1110; single mack pulse, d_le stays 0.
- BERR_n and DTACK_n asserted on the same edge during a word read @2: one mberr pulse, no mack; RECOV holds until both pins return high.
- Z3M_TIMEOUT_EN, TIMEOUT_CYCLES=8, no slave response: mberr pulses after 8 DATA cycles and timeout=1; the next accepted mreq clears timeout.
- BMASTER drops in DATA: mberr next cycle, then FCS_n=1, DS_n=F, DOE=0.
- IORST_n pulsed low in DATA with a 3-byte@1 write in flight: immediate FCS_n=1, DS_n=F, DOE=0, busy=0; no pulses after release.

Source files
------------

// File: rtl/z3_pkg.sv
// z3_pkg: definitions shared by the Zorro III bus blocks.
//   z3_state_e   - master cycle sequencer states
//   SIZ_*        - NCR transfer-size encodings
//   DS_*         - DS_n bit index of each byte lane (DS_n[3] = D31:24, offset 0)
//   siz_bytes()  - byte count of a size encoding (00 means four bytes)
package z3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ACK,
        ERR,
        RECOV
    } z3_state_e;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    localparam int DS_D31_24 = 3;
    localparam int DS_D23_16 = 2;
    localparam int DS_D15_8  = 1;
    localparam int DS_D7_0   = 0;

    function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
        return (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
    endfunction

endpackage

// File: rtl/z3_lane_decode.sv
// z3_lane_decode: byte-lane strobe mask for a Zorro III transfer (combinational).
//   msiz    in  2  transfer size (00 long, 01 byte, 10 word, 11 three-byte)
//   maddr   in  2  A[1:0] of the transfer
//   ds_mask out 4  active-low lane strobes; offset k drives bit 3-k
// Lanes run from maddr upward and are clipped at offset 3, so a misaligned
// long only strobes the lanes that fit in the addressed longword.
module z3_lane_decode
    import z3_pkg::*;
(
    input  logic [1:0] msiz,
    input  logic [1:0] maddr,
    output logic [3:0] ds_mask
);

    logic [2:0] first;
    logic [2:0] last;

    assign first = {1'b0, maddr};
    assign last  = first + siz_bytes(msiz) - 3'd1;

    always_comb begin
        ds_mask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) >= first && 3'(k) <= last)
                ds_mask[3-k] = 1'b0;
        end
    end

endmodule

// File: rtl/z3_master_cycle.sv
// z3_master_cycle: Zorro III bus-master cycle sequencer.
// Converts each NCR DMA request into one Zorro III cycle while the bus is
// granted, and returns a one-cycle mack or mberr to the NCR side.
//   CLK, IORST_n          clock, async active-low reset
//   BMASTER               bus grant
//   mreq/mread/msiz/maddr NCR request and its attributes
//   DTACK_n, BERR_n       asynchronous slave responses
//   FCS_n, READ, DOE, DS_n  Zorro cycle outputs
//   d_le, mack, mberr     one-cycle results to the NCR side
//   timeout               sticky timeout flag, busy = not IDLE
// Build option: define Z3M_TIMEOUT_EN to build the DATA-state timeout timer;
// otherwise DATA waits indefinitely and timeout is tied low.
module z3_master_cycle
    import z3_pkg::*;
#(
    parameter int ADDR_SETUP     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       IORST_n,
    input  logic       BMASTER,
    input  logic       mreq,
    input  logic       mread,
    input  logic [1:0] msiz,
    input  logic [1:0] maddr,
    input  logic       DTACK_n,
    input  logic       BERR_n,
    output logic       FCS_n,
    output logic       READ,
    output logic       DOE,
    output logic [3:0] DS_n,
    output logic       d_le,
    output logic       mack,
    output logic       mberr,
    output logic       timeout,
    output logic       busy
);

    z3_state_e  state, nstate;
    logic       dt_meta, dt_s, be_meta, be_s;
    logic [1:0] siz_q, addr_q;
    logic [2:0] setup_cnt;
    logic [3:0] mask;
    logic       tmo_hit;
    logic       tmo_err;
    logic       accept;

    z3_lane_decode u_lane (
        .msiz    (siz_q),
        .maddr   (addr_q),
        .ds_mask (mask)
    );

    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            dt_meta <= 1'b1;
            dt_s    <= 1'b1;
            be_meta <= 1'b1;
            be_s    <= 1'b1;
        end else begin
            dt_meta <= DTACK_n;
            dt_s    <= dt_meta;
            be_meta <= BERR_n;
            be_s    <= be_meta;
        end
    end

`ifdef Z3M_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic          timeout_q;

    // Timer holds the number of completed DATA cycles; it is zero on DATA entry.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n)
            timer <= '0;
        else if (state != DATA)
            timer <= '0;
        else if (timer != '1)
            timer <= timer + 1'b1;
    end

    assign tmo_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n)
            timeout_q <= 1'b0;
        else if (accept)
            timeout_q <= 1'b0;
        else if (tmo_err)
            timeout_q <= 1'b1;
    end

    assign timeout = timeout_q;
`else
    logic [9:0] unused_tmo_cfg;
    assign unused_tmo_cfg = 10'(TIMEOUT_CYCLES);
    assign tmo_hit        = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign accept = (state == IDLE) && mreq && BMASTER;

    always_comb begin
        nstate  = state;
        tmo_err = 1'b0;
        case (state)
            IDLE:  if (accept) nstate = ADDR;
            ADDR: begin
                if (!BMASTER)                               nstate = ERR;
                else if (setup_cnt == 3'(ADDR_SETUP - 1))   nstate = DATA;
            end
            DATA: begin
                // Grant loss first, then BERR over DTACK, then the timer.
                if (!BMASTER)     nstate = ERR;
                else if (!be_s)   nstate = ERR;
                else if (!dt_s)   nstate = ACK;
                else if (tmo_hit) begin
                    nstate  = ERR;
                    tmo_err = 1'b1;
                end
            end
            ACK, ERR: nstate = RECOV;
            RECOV: if (dt_s && be_s) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            state     <= IDLE;
            setup_cnt <= '0;
            siz_q     <= SIZ_LONG;
            addr_q    <= 2'b00;
        end else begin
            state     <= nstate;
            setup_cnt <= (state == ADDR) ? setup_cnt + 3'd1 : 3'd0;
            if (accept) begin
                siz_q  <= msiz;
                addr_q <= maddr;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            FCS_n <= 1'b1;
            READ  <= 1'b1;
            DOE   <= 1'b0;
            DS_n  <= 4'hF;
            d_le  <= 1'b0;
            mack  <= 1'b0;
            mberr <= 1'b0;
            busy  <= 1'b0;
        end else begin
            FCS_n <= !(nstate inside {ADDR, DATA, ACK, ERR});
            DOE   <= nstate inside {DATA, ACK, ERR};
            DS_n  <= (nstate inside {DATA, ACK, ERR}) ? mask : 4'hF;
            d_le  <= (nstate == ACK) && READ;
            mack  <= (nstate == ACK);
            mberr <= (nstate == ERR);
            busy  <= (nstate != IDLE);
            if (accept)
                READ <= mread;
        end
    end

endmodule

// File: tb/tb_z3_master_cycle.sv
// tb_z3_master_cycle: directed test of z3_master_cycle.
// u1 uses ADDR_SETUP=1, u2 uses ADDR_SETUP=2; both share stimulus.
// Build option Z3M_TIMEOUT_EN selects the timeout scenario.
module tb_z3_master_cycle;

    logic       CLK = 1'b0;
    logic       IORST_n, BMASTER, mreq, mread, DTACK_n, BERR_n;
    logic [1:0] msiz, maddr;

    logic       FCS_n, READ, DOE, d_le, mack, mberr, timeout, busy;
    logic [3:0] DS_n;
    logic       b_FCS_n, b_READ, b_DOE, b_d_le, b_mack, b_mberr, b_timeout, b_busy;
    logic [3:0] b_DS_n;

    int errs   = 0;
    int checks = 0;

    always #20 CLK = ~CLK;

    z3_master_cycle #(.ADDR_SETUP(1), .TIMEOUT_CYCLES(8)) u1 (
        .CLK(CLK), .IORST_n(IORST_n), .BMASTER(BMASTER), .mreq(mreq), .mread(mread),
        .msiz(msiz), .maddr(maddr), .DTACK_n(DTACK_n), .BERR_n(BERR_n),
        .FCS_n(FCS_n), .READ(READ), .DOE(DOE), .DS_n(DS_n), .d_le(d_le),
        .mack(mack), .mberr(mberr), .timeout(timeout), .busy(busy)
    );

    z3_master_cycle #(.ADDR_SETUP(2), .TIMEOUT_CYCLES(8)) u2 (
        .CLK(CLK), .IORST_n(IORST_n), .BMASTER(BMASTER), .mreq(mreq), .mread(mread),
        .msiz(msiz), .maddr(maddr), .DTACK_n(DTACK_n), .BERR_n(BERR_n),
        .FCS_n(b_FCS_n), .READ(b_READ), .DOE(b_DOE), .DS_n(b_DS_n), .d_le(b_d_le),
        .mack(b_mack), .mberr(b_mberr), .timeout(b_timeout), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic rd, input logic [1:0] siz, input logic [1:0] adr);
        mreq  = 1'b1;
        mread = rd;
        msiz  = siz;
        maddr = adr;
    endtask

    task automatic settle(input string tag);
        mreq    = 1'b0;
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
        repeat (5) tick();
        chk({tag, "_idle1"}, busy, 1'b0);
        chk({tag, "_idle2"}, b_busy, 1'b0);
    endtask

    initial begin
        IORST_n = 1'b0; BMASTER = 1'b1; mreq = 1'b0; mread = 1'b0;
        msiz = 2'b00; maddr = 2'b00; DTACK_n = 1'b1; BERR_n = 1'b1;
        #50;
        chk("rst_fcs",  FCS_n, 1'b1);
        chk("rst_ds",   DS_n, 4'hF);
        chk("rst_doe",  DOE, 1'b0);
        chk("rst_read", READ, 1'b1);
        chk("rst_puls", {d_le, mack, mberr}, 3'b000);
        chk("rst_tmo",  timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge CLK);
        IORST_n = 1'b1;
        repeat (2) tick();

        // Long read @0, DTACK_n low four cycles after the strobes.
        req(1'b1, 2'b00, 2'b00);
        tick();
        chk("lr_fcs_addr", FCS_n, 1'b0);
        chk("lr_doe_addr", DOE, 1'b0);
        chk("lr_busy",     busy, 1'b1);
        tick();
        chk("lr_doe",  DOE, 1'b1);
        chk("lr_ds",   DS_n, 4'h0);
        chk("lr_read", READ, 1'b1);
        repeat (3) tick();
        DTACK_n = 1'b0;
        tick();
        chk("lr_ack_e1", mack, 1'b0);
        tick();
        chk("lr_ack_e2", mack, 1'b0);
        tick();
        chk("lr_mack", mack, 1'b1);
        chk("lr_dle",  d_le, 1'b1);
        chk("lr_fcs_ack", FCS_n, 1'b0);
        mreq = 1'b0;
        tick();
        chk("lr_fcs_recov", FCS_n, 1'b1);
        chk("lr_mack_once", mack, 1'b0);
        chk("lr_ds_recov",  DS_n, 4'hF);
        settle("lr");

        // Byte write @3 on the ADDR_SETUP=2 instance.
        req(1'b0, 2'b01, 2'b11);
        tick();
        chk("bw_fcs1", {b_FCS_n, b_DOE}, 2'b00);
        tick();
        chk("bw_fcs2", {b_FCS_n, b_DOE}, 2'b00);
        tick();
        chk("bw_doe", b_DOE, 1'b1);
        chk("bw_ds",  b_DS_n, 4'hE);
        DTACK_n = 1'b0;
        repeat (3) tick();
        chk("bw_mack", b_mack, 1'b1);
        chk("bw_dle",  b_d_le, 1'b0);
        mreq = 1'b0;
        tick();
        chk("bw_mack_once", b_mack, 1'b0);
        settle("bw");

        // Word read @2 with BERR_n and DTACK_n on the same edge.
        req(1'b1, 2'b10, 2'b10);
        repeat (2) tick();
        chk("be_ds", DS_n, 4'hC);
        DTACK_n = 1'b0;
        BERR_n  = 1'b0;
        repeat (3) tick();
        chk("be_mberr", {mberr, mack}, 2'b10);
        mreq = 1'b0;
        tick();
        chk("be_once", {mberr, mack}, 2'b00);
        DTACK_n = 1'b1;
        repeat (4) tick();
        chk("be_recov_busy", busy, 1'b1);
        chk("be_recov_fcs",  FCS_n, 1'b1);
        settle("be");

        // Grant lost in DATA.
        req(1'b1, 2'b00, 2'b00);
        repeat (2) tick();
        BMASTER = 1'b0;
        tick();
        chk("bm_mberr", {mberr, mack}, 2'b10);
        mreq = 1'b0;
        tick();
        chk("bm_bus", {FCS_n, DS_n, DOE}, {1'b1, 4'hF, 1'b0});
        BMASTER = 1'b1;
        settle("bm");

`ifdef Z3M_TIMEOUT_EN
        // No slave response: error after eight DATA cycles.
        req(1'b1, 2'b00, 2'b00);
        repeat (2) tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait", mberr, 1'b0);
        end
        tick();
        chk("to_mberr", mberr, 1'b1);
        chk("to_flag",  timeout, 1'b1);
        mreq = 1'b0;
        repeat (4) tick();
        chk("to_sticky", timeout, 1'b1);
        req(1'b0, 2'b00, 2'b00);
        tick();
        chk("to_clear", timeout, 1'b0);
        tick();
        DTACK_n = 1'b0;
        repeat (3) tick();
        chk("to_next_mack", mack, 1'b1);
        settle("to");
`else
        // No timer built: DATA waits well beyond any timeout.
        req(1'b1, 2'b00, 2'b00);
        repeat (14) tick();
        chk("nt_wait", {busy, mberr, timeout, DOE}, 4'b1001);
        DTACK_n = 1'b0;
        repeat (3) tick();
        chk("nt_mack", mack, 1'b1);
        settle("nt");
`endif

        // Reset mid-DATA with a 3-byte write @1 in flight.
        req(1'b0, 2'b11, 2'b01);
        repeat (2) tick();
        chk("rs_ds",   DS_n, 4'h8);
        chk("rs_read", READ, 1'b0);
        #5;
        IORST_n = 1'b0;
        #1;
        chk("rs_bus",  {FCS_n, DS_n, DOE, busy}, {1'b1, 4'hF, 1'b0, 1'b0});
        mreq = 1'b0;
        @(negedge CLK);
        IORST_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rs_nopulse", {mack, mberr, busy}, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
